// File: rtl/uart_pkg.sv
// Shared UART types, default constants and the parity helper used by both uart_rx and uart_tx.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_MAX_BITS   = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    // Narrower frames are zero-extended by the caller; zero bits do not change the XOR.
    function automatic logic parity_bit(input logic [UART_MAX_BITS-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
    input  logic mclkx16,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge mclkx16 or negedge reset) begin
        if (!reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver with holding register, ready flag and framing/overrun status.
// Define UART_RX_PARITY_EN to receive and check one parity bit after the data bits.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int PARITY_ODD = 0
) (
    input  logic                 mclkx16,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 read,
    output logic [DATA_BITS-1:0] data,
    output logic                 rxrdy,
    output logic                 framerr,
    output logic                 parerr,
    output logic                 overrun
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS);

    localparam logic [TICK_W-1:0] HALF_TICK = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > UART_MAX_BITS) begin : g_bad_data_bits
        $error("uart_rx: DATA_BITS must be 5..8");
    end
    if (OVERSAMPLE < 4 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_oversample
        $error("uart_rx: OVERSAMPLE must be a power of two, at least 4");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
        $error("uart_rx: PARITY_ODD must be 0 or 1");
    end

    rx_state_t             state;
    rx_state_t             state_next;
    logic                  rx_s;
    logic [TICK_W-1:0]     tick;
    logic [BIT_W-1:0]      bitcnt;
    logic [DATA_BITS-1:0]  shreg;
    logic                  stop_bit;
    logic                  load;
    logic                  mid_start;
    logic                  bit_tick;

    uart_rx_sync u_sync (
        .mclkx16 (mclkx16),
        .reset   (reset),
        .d       (rx),
        .q       (rx_s)
    );

    // After the start-bit centre the counter restarts, so every later centre is at LAST_TICK.
    assign mid_start = (tick == HALF_TICK);
    assign bit_tick  = (tick == LAST_TICK);

    always_ff @(posedge mclkx16 or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                end
            end
            START: begin
                if (mid_start) begin
                    state_next = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_tick && bitcnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_tick) begin
                    state_next = rx_s ? IDLE : BREAK;
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The stop sample is registered and the holding register loads one edge later.
    always_ff @(posedge mclkx16 or negedge reset) begin
        if (!reset) begin
            tick     <= '0;
            bitcnt   <= '0;
            shreg    <= '0;
            stop_bit <= 1'b0;
            load     <= 1'b0;
        end else begin
            load <= 1'b0;
            case (state)
                IDLE, BREAK: begin
                    tick <= '0;
                end
                START: begin
                    tick   <= mid_start ? '0 : tick + 1'b1;
                    bitcnt <= '0;
                end
                default: begin
                    tick <= tick + 1'b1;
                end
            endcase
            if (state == DATA && bit_tick) begin
                shreg  <= {rx_s, shreg[DATA_BITS-1:1]};
                bitcnt <= bitcnt + 1'b1;
            end
            if (state == STOP && bit_tick) begin
                stop_bit <= rx_s;
                load     <= 1'b1;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_mismatch;

    always_ff @(posedge mclkx16 or negedge reset) begin
        if (!reset) begin
            par_mismatch <= 1'b0;
        end else if (state == PARITY && bit_tick) begin
            par_mismatch <= rx_s ^ parity_bit(UART_MAX_BITS'(shreg), (PARITY_ODD != 0));
        end
    end
`else
    assign parerr = 1'b0;
`endif

    // A load takes priority over a coincident read; overrun only counts an unread, unconsumed frame.
    always_ff @(posedge mclkx16 or negedge reset) begin
        if (!reset) begin
            data    <= '0;
            rxrdy   <= 1'b0;
            framerr <= 1'b0;
            overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parerr  <= 1'b0;
`endif
        end else if (load) begin
            data    <= shreg;
            rxrdy   <= 1'b1;
            framerr <= ~stop_bit;
            overrun <= rxrdy & ~read;
`ifdef UART_RX_PARITY_EN
            parerr  <= par_mismatch;
`endif
        end else if (read && rxrdy) begin
            rxrdy   <= 1'b0;
            framerr <= 1'b0;
            overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parerr  <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: frames are driven bit by bit on the falling clock edge, outputs checked on falling edges.
`timescale 1ns/1ps
module tb_uart_rx;

    logic       mclkx16 = 1'b0;
    logic       reset   = 1'b1;
    logic       rx      = 1'b1;
    logic       read    = 1'b0;
    logic [7:0] data;
    logic       rxrdy;
    logic       framerr;
    logic       parerr;
    logic       overrun;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    uart_rx dut (
        .mclkx16 (mclkx16),
        .reset   (reset),
        .rx      (rx),
        .read    (read),
        .data    (data),
        .rxrdy   (rxrdy),
        .framerr (framerr),
        .parerr  (parerr),
        .overrun (overrun)
    );

    always #3255 mclkx16 = ~mclkx16;

    initial begin
        #(64'd6510 * 64'd20000);
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic send_bit(input logic v);
        rx = v;
        repeat (16) @(negedge mclkx16);
    endtask

    // The load edge is the 156th rising edge after the start-bit negedge (172nd with parity),
    // i.e. stop-bit negedge index 11 drives read high across exactly that edge.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic read_at_load);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^b) ^ par_flip);
`endif
        rx = stop;
        for (int k = 0; k < 16; k++) begin
            read = read_at_load && (k == 11);
            @(negedge mclkx16);
        end
        read = 1'b0;
    endtask

    task automatic pulse_read();
        read = 1'b1;
        @(negedge mclkx16);
        read = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #5 reset = 1'b1;
        @(negedge mclkx16);
        n_cmp++; if ({data, rxrdy, framerr, parerr, overrun} !== 12'h000) begin n_fail++; $display("[TB] FAIL reset_outputs: got %h want %h", {data, rxrdy, framerr, parerr, overrun}, 12'h000); end
        repeat (4) @(negedge mclkx16);
    endtask

    task automatic test_basic_frame();
        send_frame(8'h07, 1'b1, 1'b0);
        n_cmp++; if (data !== 8'h07) begin n_fail++; $display("[TB] FAIL basic_data: got %h want %h", data, 8'h07); end
        n_cmp++; if (rxrdy !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_rxrdy: got %b want 1", rxrdy); end
        n_cmp++; if (framerr !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_framerr: got %b want 0", framerr); end
        n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_overrun: got %b want 0", overrun); end
        n_cmp++; if (parerr !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_parerr: got %b want 0", parerr); end
        pulse_read();
        n_cmp++; if (rxrdy !== 1'b0) begin n_fail++; $display("[TB] FAIL read_clears_rxrdy: got %b want 0", rxrdy); end
        n_cmp++; if (data !== 8'h07) begin n_fail++; $display("[TB] FAIL read_holds_data: got %h want %h", data, 8'h07); end
        pulse_read();
        n_cmp++; if ({data, rxrdy} !== {8'h07, 1'b0}) begin n_fail++; $display("[TB] FAIL idle_read_no_effect: got %h want %h", {data, rxrdy}, {8'h07, 1'b0}); end
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        repeat (4) @(negedge mclkx16);
        rx = 1'b1;
        repeat (40) @(negedge mclkx16);
        n_cmp++; if (rxrdy !== 1'b0) begin n_fail++; $display("[TB] FAIL glitch_rxrdy: got %b want 0", rxrdy); end
        send_frame(8'hC3, 1'b1, 1'b0);
        n_cmp++; if ({data, rxrdy, framerr} !== {8'hC3, 1'b1, 1'b0}) begin n_fail++; $display("[TB] FAIL after_glitch_frame: got %h want %h", {data, rxrdy, framerr}, {8'hC3, 1'b1, 1'b0}); end
        pulse_read();
    endtask

    task automatic test_break();
        send_frame(8'hA5, 1'b0, 1'b0);
        n_cmp++; if (data !== 8'hA5) begin n_fail++; $display("[TB] FAIL break_data: got %h want %h", data, 8'hA5); end
        n_cmp++; if (framerr !== 1'b1) begin n_fail++; $display("[TB] FAIL break_framerr: got %b want 1", framerr); end
        n_cmp++; if (rxrdy !== 1'b1) begin n_fail++; $display("[TB] FAIL break_rxrdy: got %b want 1", rxrdy); end
        pulse_read();
        n_cmp++; if ({rxrdy, framerr} !== 2'b00) begin n_fail++; $display("[TB] FAIL break_read_clear: got %b want %b", {rxrdy, framerr}, 2'b00); end
        // Held low for longer than a whole frame, so any false start would have completed a load.
        repeat (200) @(negedge mclkx16);
        n_cmp++; if (rxrdy !== 1'b0) begin n_fail++; $display("[TB] FAIL break_no_start: got %b want 0", rxrdy); end
        rx = 1'b1;
        repeat (16) @(negedge mclkx16);
        send_frame(8'h3C, 1'b1, 1'b0);
        n_cmp++; if ({data, rxrdy, framerr, overrun} !== {8'h3C, 1'b1, 1'b0, 1'b0}) begin n_fail++; $display("[TB] FAIL after_break_frame: got %h want %h", {data, rxrdy, framerr, overrun}, {8'h3C, 1'b1, 1'b0, 1'b0}); end
        pulse_read();
    endtask

    task automatic test_back_to_back();
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        n_cmp++; if (data !== 8'h22) begin n_fail++; $display("[TB] FAIL b2b_data: got %h want %h", data, 8'h22); end
        n_cmp++; if (overrun !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_overrun: got %b want 1", overrun); end
        n_cmp++; if (rxrdy !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_rxrdy: got %b want 1", rxrdy); end
        pulse_read();
        n_cmp++; if ({rxrdy, overrun} !== 2'b00) begin n_fail++; $display("[TB] FAIL overrun_read_clear: got %b want %b", {rxrdy, overrun}, 2'b00); end
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b1);
        n_cmp++; if ({data, rxrdy, overrun} !== {8'h22, 1'b1, 1'b0}) begin n_fail++; $display("[TB] FAIL read_at_load: got %h want %h", {data, rxrdy, overrun}, {8'h22, 1'b1, 1'b0}); end
        pulse_read();
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        par_flip = 1'b0;
        send_frame(8'h07, 1'b1, 1'b0);
        n_cmp++; if ({data, parerr} !== {8'h07, 1'b0}) begin n_fail++; $display("[TB] FAIL parity_good: got %h want %h", {data, parerr}, {8'h07, 1'b0}); end
        pulse_read();
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1, 1'b0);
        par_flip = 1'b0;
        n_cmp++; if ({data, parerr} !== {8'h07, 1'b1}) begin n_fail++; $display("[TB] FAIL parity_bad: got %h want %h", {data, parerr}, {8'h07, 1'b1}); end
        pulse_read();
        n_cmp++; if (parerr !== 1'b0) begin n_fail++; $display("[TB] FAIL parity_read_clear: got %b want 0", parerr); end
    endtask
`endif

    task automatic test_reset_mid_frame();
        send_frame(8'h99, 1'b1, 1'b0);
        n_cmp++; if ({data, rxrdy} !== {8'h99, 1'b1}) begin n_fail++; $display("[TB] FAIL pre_reset_frame: got %h want %h", {data, rxrdy}, {8'h99, 1'b1}); end
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        reset = 1'b0;
        #1;
        n_cmp++; if ({data, rxrdy, framerr, parerr, overrun} !== 12'h000) begin n_fail++; $display("[TB] FAIL mid_frame_reset: got %h want %h", {data, rxrdy, framerr, parerr, overrun}, 12'h000); end
        rx = 1'b1;
        @(negedge mclkx16);
        @(negedge mclkx16);
        reset = 1'b1;
        repeat (20) @(negedge mclkx16);
        send_frame(8'h5A, 1'b1, 1'b0);
        n_cmp++; if ({data, rxrdy} !== {8'h5A, 1'b1}) begin n_fail++; $display("[TB] FAIL post_reset_frame: got %h want %h", {data, rxrdy}, {8'h5A, 1'b1}); end
        n_cmp++; if ({framerr, parerr, overrun} !== 3'b000) begin n_fail++; $display("[TB] FAIL post_reset_flags: got %b want %b", {framerr, parerr, overrun}, 3'b000); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_glitch();
        test_break();
        test_back_to_back();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
